// File: rtl/player_move.sv
// Per-frame player sprite motion: constant-speed horizontal walk, jump-plus-gravity vertical motion.
// Optional macro PLAYER_WRAP_EN makes X wrap around the screen instead of clamping at the edges.
module player_move #(
    parameter int INITIAL_X              = 280,
    parameter int INITIAL_Y              = 185,
    parameter int OBJECT_WIDTH_X         = 32,
    parameter int OBJECT_HEIGHT_Y        = 32,
    parameter int SCREEN_WIDTH           = 640,
    parameter int FLOOR_Y                = 440,
    parameter int X_SPEED                = 4,
    parameter int JUMP_SPEED             = 12,
    parameter int GRAVITY_FP             = 32,
    parameter int MAX_FALL_SPEED         = 16,
    parameter int FIXED_POINT_MULTIPLIER = 64
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        leftKey,
    input  logic        rightKey,
    input  logic        jumpKey,
    input  logic        collision,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        airborne
);

    localparam int FP_SHIFT   = $clog2(FIXED_POINT_MULTIPLIER);
    localparam int FP         = FIXED_POINT_MULTIPLIER;
    localparam int X_STEP     = X_SPEED * FP;
    localparam int JUMP_V     = -(JUMP_SPEED * FP);
    localparam int MAX_FALL   = MAX_FALL_SPEED * FP;
    localparam int FLOOR_LIM  = (FLOOR_Y - OBJECT_HEIGHT_Y) * FP;
    localparam int INIT_X_FP  = INITIAL_X * FP;
    localparam int INIT_Y_FP  = INITIAL_Y * FP;
`ifdef PLAYER_WRAP_EN
    localparam int SCREEN_FP  = SCREEN_WIDTH * FP;
`else
    localparam int X_MAX      = (SCREEN_WIDTH - OBJECT_WIDTH_X) * FP;
`endif

    typedef enum logic {S_GROUND, S_AIR} state_t;

    state_t             state;
    state_t             stateNext;
    logic signed [31:0] xPos;
    logic signed [31:0] yPos;
    logic signed [31:0] ySpeed;
    logic signed [31:0] xNext;
    logic signed [31:0] yNext;
    logic signed [31:0] ySpeedNext;
    logic signed [31:0] xStep;
    logic signed [31:0] xSum;
    logic signed [31:0] xTarget;
    logic signed [31:0] airSpeed;
    logic               jumpPrev;
    logic               jumpReq;
    logic               hitLatch;
    logic               jumpEdge;
    logic               jumpNow;
    logic               hitNow;

    // Events seen during the startOfFrame cycle itself still count for that frame.
    assign jumpEdge = jumpKey & ~jumpPrev;
    assign jumpNow  = jumpReq | jumpEdge;
    assign hitNow   = hitLatch | collision;

    always_comb begin
        xStep = '0;
        if (rightKey && !leftKey) begin
            xStep = X_STEP;
        end else if (leftKey && !rightKey) begin
            xStep = -X_STEP;
        end
        xSum    = xPos + xStep;
        xTarget = xSum;
`ifdef PLAYER_WRAP_EN
        if (xSum < 0) begin
            xTarget = xSum + SCREEN_FP;
        end else if (xSum >= SCREEN_FP) begin
            xTarget = xSum - SCREEN_FP;
        end
`else
        if (xSum < 0) begin
            xTarget = '0;
        end else if (xSum > X_MAX) begin
            xTarget = X_MAX;
        end
`endif
    end

    always_comb begin
        stateNext  = state;
        xNext      = xPos;
        yNext      = yPos;
        ySpeedNext = ySpeed;
        airSpeed   = ySpeed;
        if (startOfFrame) begin
            xNext = xTarget;
            case (state)
                S_GROUND: begin
                    if (jumpNow) begin
                        ySpeedNext = JUMP_V;
                        yNext      = yPos + JUMP_V;
                        stateNext  = S_AIR;
                    end
                end
                S_AIR: begin
                    // A hit only matters while rising; it kills upward speed before the move.
                    if (hitNow && ySpeed < 0) begin
                        airSpeed = '0;
                    end
                    yNext      = yPos + airSpeed;
                    ySpeedNext = airSpeed + GRAVITY_FP;
                    if (ySpeedNext > MAX_FALL) begin
                        ySpeedNext = MAX_FALL;
                    end
                    if (yNext < 0) begin
                        yNext      = '0;
                        ySpeedNext = '0;
                    end
                    if (yNext >= FLOOR_LIM) begin
                        yNext      = FLOOR_LIM;
                        ySpeedNext = '0;
                        stateNext  = S_GROUND;
                    end
                end
                default: stateNext = S_AIR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state    <= S_AIR;
            xPos     <= INIT_X_FP;
            yPos     <= INIT_Y_FP;
            ySpeed   <= '0;
            jumpPrev <= 1'b0;
            jumpReq  <= 1'b0;
            hitLatch <= 1'b0;
            topLeftX <= 11'(INITIAL_X);
            topLeftY <= 11'(INITIAL_Y);
        end else begin
            state    <= stateNext;
            xPos     <= xNext;
            yPos     <= yNext;
            ySpeed   <= ySpeedNext;
            jumpPrev <= jumpKey;
            topLeftX <= 11'(xNext >>> FP_SHIFT);
            topLeftY <= 11'(yNext >>> FP_SHIFT);
            if (startOfFrame) begin
                jumpReq  <= 1'b0;
                hitLatch <= 1'b0;
            end else begin
                if (jumpEdge) begin
                    jumpReq <= 1'b1;
                end
                if (collision) begin
                    hitLatch <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        airborne = (state == S_AIR);
    end

endmodule

// File: tb/tb_player_move.sv
// Testbench for player_move: directed vector table, hand-written jump sequences and a randomized
// phase checked against a frame-level behavioural model. Honours PLAYER_WRAP_EN like the design.
module tb_player_move;

    localparam int INITIAL_X       = 280;
    localparam int INITIAL_Y       = 185;
    localparam int OBJECT_WIDTH_X  = 32;
    localparam int OBJECT_HEIGHT_Y = 32;
    localparam int SCREEN_WIDTH    = 640;
    localparam int FLOOR_Y         = 440;
    localparam int X_SPEED         = 4;
    localparam int JUMP_SPEED      = 12;
    localparam int GRAVITY_FP      = 32;
    localparam int MAX_FALL_SPEED  = 16;
    localparam int FP              = 64;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        leftKey;
    logic        rightKey;
    logic        jumpKey;
    logic        collision;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        airborne;

    int checks   = 0;
    int failures = 0;

    player_move dut (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .leftKey     (leftKey),
        .rightKey    (rightKey),
        .jumpKey     (jumpKey),
        .collision   (collision),
        .topLeftX    (topLeftX),
        .topLeftY    (topLeftY),
        .airborne    (airborne)
    );

    always #5 clk = ~clk;

    // Reference model state, in 1/FP pixel units.
    int mX, mY, mVy;
    bit mAir, mPrev, mJumpPend, mHitPend;
    bit modelCheck = 1'b0;

    function automatic int clampInt(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic modelFrame(input bit l, input bit r, input bit jump, input bit hit);
        int dir;
        int screenFp;
        dir = int'(r) - int'(l);
        screenFp = SCREEN_WIDTH * FP;
        mX = mX + dir * X_SPEED * FP;
`ifdef PLAYER_WRAP_EN
        mX = ((mX % screenFp) + screenFp) % screenFp;
`else
        mX = clampInt(mX, 0, screenFp - OBJECT_WIDTH_X * FP);
`endif
        if (!mAir) begin
            if (jump) begin
                mVy  = -JUMP_SPEED * FP;
                mY   = mY + mVy;
                mAir = 1'b1;
            end
        end else begin
            if (hit && mVy < 0) mVy = 0;
            mY  = mY + mVy;
            mVy = clampInt(mVy + GRAVITY_FP, -1000000, MAX_FALL_SPEED * FP);
            if (mY < 0) begin
                mY  = 0;
                mVy = 0;
            end
            if (mY >= (FLOOR_Y - OBJECT_HEIGHT_Y) * FP) begin
                mY   = (FLOOR_Y - OBJECT_HEIGHT_Y) * FP;
                mVy  = 0;
                mAir = 1'b0;
            end
        end
    endtask

    task automatic modelClock(input bit rstN, input bit sof, input bit l, input bit r,
                              input bit j, input bit c);
        bit edgeSeen;
        if (!rstN) begin
            mX = INITIAL_X * FP;
            mY = INITIAL_Y * FP;
            mVy = 0;
            mAir = 1'b1;
            mPrev = 1'b0;
            mJumpPend = 1'b0;
            mHitPend = 1'b0;
        end else begin
            edgeSeen = j && !mPrev;
            mPrev = j;
            if (sof) begin
                modelFrame(l, r, mJumpPend || edgeSeen, mHitPend || c);
                mJumpPend = 1'b0;
                mHitPend = 1'b0;
            end else begin
                if (edgeSeen) mJumpPend = 1'b1;
                if (c) mHitPend = 1'b1;
            end
        end
    endtask

    task automatic checkOutput(input string name, input int eX, input int eY, input bit eAir);
        checks++;
        if (int'(topLeftX) != eX || int'(topLeftY) != eY || airborne !== eAir) begin
            failures++;
            $display("[TB] FAIL %s: got X=%0d Y=%0d air=%0b, expected X=%0d Y=%0d air=%0b",
                     name, topLeftX, topLeftY, airborne, eX, eY, eAir);
        end
    endtask

    task automatic applyStimulus(input bit rstN, input bit sof, input bit l, input bit r,
                                 input bit j, input bit c);
        @(negedge clk);
        resetN = rstN;
        startOfFrame = sof;
        leftKey = l;
        rightKey = r;
        jumpKey = j;
        collision = c;
        @(posedge clk);
        modelClock(rstN, sof, l, r, j, c);
        #1;
        if (modelCheck) checkOutput("model", mX / FP, mY / FP, mAir);
    endtask

    // Three idle cycles with the keys applied, then the startOfFrame cycle carrying the collision.
    task automatic runFrame(input bit l, input bit r, input bit j, input bit c);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, l, r, j, 1'b0);
        applyStimulus(1'b1, 1'b1, l, r, j, c);
    endtask

    typedef struct {
        string name;
        bit    l;
        bit    r;
        bit    j;
        int    frames;
        int    expX;
        int    expY;
        bit    expAir;
    } vec_t;

    vec_t vecs[10];
    int   xK;
    int   prevY;
    bit   monotonic;
    bit   rl, rr, rj, rs, rc, rrst;

    initial begin
        vecs[0] = '{"dropToFloor", 1'b0, 1'b0, 1'b0, 120, 280, 408, 1'b0};
        vecs[1] = '{"walkRight",   1'b0, 1'b1, 1'b0, 10,  320, 408, 1'b0};
        vecs[2] = '{"bothKeys",    1'b1, 1'b1, 1'b0, 5,   320, 408, 1'b0};
        vecs[3] = '{"jumpPress",   1'b0, 1'b0, 1'b1, 1,   320, 396, 1'b1};
        vecs[4] = '{"jumpHeld",    1'b0, 1'b0, 1'b1, 199, 320, 408, 1'b0};
        vecs[5] = '{"jumpRelease", 1'b0, 1'b0, 1'b0, 1,   320, 408, 1'b0};
        vecs[6] = '{"walkLeft",    1'b1, 1'b0, 1'b0, 79,  4,   408, 1'b0};
        vecs[7] = '{"leftEdge1",   1'b1, 1'b0, 1'b0, 1,   0,   408, 1'b0};
`ifdef PLAYER_WRAP_EN
        vecs[8] = '{"leftEdge2",   1'b1, 1'b0, 1'b0, 1,   636, 408, 1'b0};
        vecs[9] = '{"leftEdge3",   1'b1, 1'b0, 1'b0, 1,   632, 408, 1'b0};
        xK = 632;
`else
        vecs[8] = '{"leftEdge2",   1'b1, 1'b0, 1'b0, 1,   0,   408, 1'b0};
        vecs[9] = '{"leftEdge3",   1'b1, 1'b0, 1'b0, 1,   0,   408, 1'b0};
        xK = 0;
`endif

        resetN = 1'b0;
        startOfFrame = 1'b0;
        leftKey = 1'b0;
        rightKey = 1'b0;
        jumpKey = 1'b0;
        collision = 1'b0;

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset", 280, 185, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("idleHold", 280, 185, 1'b1);

        for (int v = 0; v < 10; v++) begin
            for (int f = 0; f < vecs[v].frames; f++) runFrame(vecs[v].l, vecs[v].r, vecs[v].j, 1'b0);
            checkOutput(vecs[v].name, vecs[v].expX, vecs[v].expY, vecs[v].expAir);
        end

        // Head bump: jump, then collide in the startOfFrame cycle while rising.
        runFrame(1'b0, 1'b0, 1'b0, 1'b0);
        runFrame(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("bumpJump", xK, 396, 1'b1);
        runFrame(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("bumpFrame", xK, 396, 1'b1);
        runFrame(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("bumpFall1", xK, 396, 1'b1);
        runFrame(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("bumpFall2", xK, 397, 1'b1);
        monotonic = 1'b1;
        prevY = 397;
        for (int f = 0; f < 30; f++) begin
            runFrame(1'b0, 1'b0, 1'b0, 1'b0);
            if (int'(topLeftY) < prevY) monotonic = 1'b0;
            prevY = int'(topLeftY);
        end
        checks++;
        if (!monotonic) begin
            failures++;
            $display("[TB] FAIL bumpMonotonic: got a rising Y after the bump, expected non-decreasing Y");
        end
        checkOutput("bumpLanded", xK, 408, 1'b0);

        // Reset in mid-air with the jump key still held.
        runFrame(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("midJumpUp", xK, 396, 1'b1);
        for (int f = 0; f < 3; f++) runFrame(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("midJumpReset", 280, 185, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("postResetHold", 280, 185, 1'b1);

        // Randomized phase, compared against the model every cycle.
        modelCheck = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rl = 1'b0;
        rr = 1'b0;
        rj = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                rl = 1'($urandom_range(0, 1));
                rr = 1'($urandom_range(0, 1));
                rj = 1'($urandom_range(0, 1));
            end
            rs   = ($urandom_range(0, 3) == 0);
            rc   = ($urandom_range(0, 11) == 0);
            rrst = ($urandom_range(0, 599) != 0);
            applyStimulus(rrst, rs, rl, rr, rrst ? rj : 1'b0, rc);
        end
        modelCheck = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
